// File: rtl/pipe_pkg.sv
// Shared types and default field widths for the pipeline-register stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int unsigned PC_W   = 30;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 5;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register: main entry drives the outputs,
// skid entry absorbs the beat accepted while downstream stalls.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = pipe_pkg::PC_W + 2 * pipe_pkg::WORD_W + pipe_pkg::REG_W + 1,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
    parameter bit ZERO_DATA_ON_FLUSH = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        level
);

    state_e              state;
    logic                in_ready_q;
    logic [DATA_W-1:0]   main_data;
    logic [CTRL_W-1:0]   main_ctrl;
    logic [DATA_W-1:0]   skid_data;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic                accept;

    assign accept = in_valid && in_ready_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            // A beat offered alongside flush handshakes but is discarded.
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            if (ZERO_DATA_ON_FLUSH) begin
                main_data <= '0;
                main_ctrl <= '0;
                skid_data <= '0;
                skid_ctrl <= '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (accept) begin
                        skid_data  <= in_data;
                        skid_ctrl  <= in_ctrl;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_data  <= skid_data;
                        main_ctrl  <= skid_ctrl;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    // Bubbles must never carry RegWr/MemWr downstream.
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign level     = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised scoreboard bench for pipe_stage_skid against an ordered-queue model.
module tb_pipe_stage_skid;

    localparam int DW = 100;
    localparam int CW = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } beat_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    level;

    logic          z_in_ready, z_out_valid;
    logic [DW-1:0] z_out_data;
    logic [CW-1:0] z_out_ctrl;
    logic [1:0]    z_level;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_FLUSH(1'b0)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .level(level)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_FLUSH(1'b1)) dut_z (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_data(z_out_data), .out_ctrl(z_out_ctrl), .level(z_level)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    beat_t         q[$];
    logic [DW-1:0] last_front = '0;
    bit            mon_en = 1'b0;
    bit            flush_prev = 1'b0;
    int            accepted = 0;
    int            emerged = 0;
    int            flushed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of at most two accepted beats.
    always @(posedge Clk) begin
        if (Rst) begin
            q.delete();
            last_front = '0;
            flush_prev = 1'b0;
            mon_en     = 1'b1;
        end else if (flush) begin
            flushed   += q.size();
            q.delete();
            flush_prev = 1'b1;
        end else begin
            bit rdy;
            flush_prev = 1'b0;
            rdy = (q.size() < 2);
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                emerged++;
            end
            if (in_valid && rdy) begin
                q.push_back('{data: in_data, ctrl: in_ctrl});
                accepted++;
            end
        end
    end

    // Monitor: compare presented outputs against the model's head of queue.
    always @(negedge Clk) begin
        if (mon_en) begin
            int sz;
            sz = q.size();
            check("level", 128'(level), 128'(sz));
            check("out_valid", 128'(out_valid), 128'(sz != 0));
            check("in_ready", 128'(in_ready), 128'(sz < 2));
            check("z_level", 128'(z_level), 128'(sz));
            check("z_out_valid", 128'(z_out_valid), 128'(sz != 0));
            check("z_in_ready", 128'(z_in_ready), 128'(sz < 2));
            if (sz != 0) begin
                check("out_data", 128'(out_data), 128'(q[0].data));
                check("out_ctrl", 128'(out_ctrl), 128'(q[0].ctrl));
                check("z_out_data", 128'(z_out_data), 128'(q[0].data));
                check("z_out_ctrl", 128'(z_out_ctrl), 128'(q[0].ctrl));
                last_front = q[0].data;
            end else begin
                check("bubble_ctrl", 128'(out_ctrl), 128'(0));
                check("z_bubble_ctrl", 128'(z_out_ctrl), 128'(0));
                check("hold_data", 128'(out_data), 128'(last_front));
                if (flush_prev) check("z_flush_zero", 128'(z_out_data), 128'(0));
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl, input logic rs);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        Rst       = rs;
        @(posedge Clk);
        #2;
    endtask

    initial begin
        int cyc;
        int start_acc;
        logic [127:0] r;

        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 1);
        check("rst_level", 128'(level), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));

        // Streaming 1,2,3 with downstream always ready.
        step(1, 100'd1, 5'b00001, 1, 0, 0);
        check("stream_lat", 128'(out_data), 128'(1));
        step(1, 100'd2, 5'b00010, 1, 0, 0);
        check("stream_2", 128'(out_data), 128'(2));
        step(1, 100'd3, 5'b00100, 1, 0, 0);
        check("stream_3", 128'(out_data), 128'(3));
        check("stream_level", 128'(level), 128'(1));
        step(0, '0, '0, 1, 0, 0);

        // Stall into skid, then drain A then B.
        step(1, 100'h11, 5'b10011, 0, 0, 0);
        step(1, 100'h22, 5'b01000, 0, 0, 0);
        check("skid_level", 128'(level), 128'(2));
        check("skid_in_ready", 128'(in_ready), 128'(0));
        check("skid_head", 128'(out_data), 128'(32'h11));
        step(0, '0, '0, 1, 0, 0);
        check("drain_b", 128'(out_data), 128'(32'h22));
        check("drain_level", 128'(level), 128'(1));
        step(0, '0, '0, 1, 0, 0);
        check("drained_ctrl", 128'(out_ctrl), 128'(0));

        // Flush while FULL with a concurrent beat.
        step(1, 100'h0a, 5'b10011, 0, 0, 0);
        step(1, 100'h0b, 5'b10011, 0, 0, 0);
        step(1, 100'h33, 5'b11111, 0, 1, 0);
        check("flush_level", 128'(level), 128'(0));
        check("flush_ctrl", 128'(out_ctrl), 128'(0));
        check("flush_zdata", 128'(z_out_data), 128'(0));
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // Reset while FULL with a beat offered.
        step(1, 100'h0c, 5'b00011, 0, 0, 0);
        step(1, 100'h0d, 5'b00011, 0, 0, 0);
        step(1, 100'h44, 5'b00011, 1, 0, 1);
        check("rst_full_level", 128'(level), 128'(0));
        check("rst_full_in_ready", 128'(in_ready), 128'(1));
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // Random handshake, stalls, flushes and occasional resets.
        start_acc = accepted;
        cyc = 0;
        while (accepted - start_acc < 1000 && cyc < 20000) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            r[15:0] = 16'(cyc);
            step($urandom_range(0, 9) < 7, r[DW-1:0], 5'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 499) == 0);
            cyc++;
        end
        if (accepted - start_acc < 1000) begin
            failures++;
            $display("FAIL random_budget: accepted %0d required 1000", accepted - start_acc);
        end
        checks++;
        for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
